// File: rtl/comb_sweep_pkg.sv
// Shared types for the combinational-loop sweep monitor: FSM states,
// the per-pattern record layout and counter widths sized for the legal parameter ranges.
package comb_sweep_pkg;

   localparam int SETTLE_MAX = 255;
   localparam int N_SAMP_MAX = 15;
   localparam int SET_W      = $clog2(SETTLE_MAX + 1);
   localparam int SAMP_W     = $clog2(N_SAMP_MAX + 1);
   // Record fields are sized for the widest supported netlist; unused upper bits stay zero.
   localparam int REC_W      = 32;

   typedef enum logic [2:0] {
      S_IDLE, S_DRIVE, S_SETTLE, S_SAMPLE, S_EMIT, S_NEXT, S_DONE
   } sweep_state_e;

   typedef struct packed {
      logic [REC_W-1:0] pattern;
      logic [REC_W-1:0] resp;
      logic [REC_W-1:0] unstable;
   } sweep_rec_t;

endpackage

// File: rtl/resp_sync.sv
// Two-flop synchronizer for the netlist outputs, which may be asynchronous or oscillating.
module resp_sync #(
   parameter int W = 5
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [W-1:0] d_i,
   output logic [W-1:0] q_o
);

   logic [W-1:0] meta_q;
   logic [W-1:0] sync_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta_q <= '0;
         sync_q <= '0;
      end else begin
         meta_q <= d_i;
         sync_q <= meta_q;
      end
   end

   assign q_o = sync_q;

endmodule

// File: rtl/comb_sweep_monitor.sv
// Exhaustive input sweep of a combLogic netlist; samples each pattern's outputs
// several times after settling and reports any output that moved (an active loop).
module comb_sweep_monitor
   import comb_sweep_pkg::*;
#(
   parameter int N_IN   = 13,
   parameter int N_OUT  = 5,
   parameter int SETTLE = 4,
   parameter int N_SAMP = 3
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            start,
   input  logic            abort,
   output logic [N_IN-1:0] pat_out,
   input  logic [N_OUT-1:0] resp_in,
   output logic            rec_valid,
   input  logic            rec_ready,
   output logic [N_IN-1:0] rec_pattern,
   output logic [N_OUT-1:0] rec_resp,
   output logic [N_OUT-1:0] rec_unstable,
   output logic            busy,
   output logic            done,
   output logic [N_IN:0]   unstable_count
);

   sweep_state_e      state_q, state_d;
   logic [N_IN-1:0]   pat_q, pat_d;
   sweep_rec_t        rec_q, rec_d;
   logic [SET_W-1:0]  set_q, set_d;
   logic [SAMP_W-1:0] samp_q, samp_d;
   logic [N_IN:0]     ucnt_q, ucnt_d;
   logic [N_OUT-1:0]  sync;
   logic              unused_rec;

   resp_sync #(.W(N_OUT)) u_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .d_i   (resp_in),
      .q_o   (sync)
   );

   assign busy = (state_q != S_IDLE) && (state_q != S_DONE);

   always_comb begin
      state_d = state_q;
      pat_d   = pat_q;
      rec_d   = rec_q;
      set_d   = set_q;
      samp_d  = samp_q;
      ucnt_d  = ucnt_q;
      unique case (state_q)
         S_IDLE, S_DONE: begin
            if (start) begin
               state_d = S_DRIVE;
               pat_d   = '0;
               ucnt_d  = '0;
            end
         end
         S_DRIVE: begin
            state_d = S_SETTLE;
            set_d   = SET_W'(SETTLE - 1);
         end
         S_SETTLE: begin
            if (set_q == '0) begin
               state_d = S_SAMPLE;
               samp_d  = '0;
            end else begin
               set_d = set_q - 1'b1;
            end
         end
         S_SAMPLE: begin
            // First sample is the reference; later ones accumulate any bit that moved.
            if (samp_q == '0) begin
               rec_d.resp     = REC_W'(sync);
               rec_d.unstable = '0;
            end else begin
               rec_d.unstable = rec_q.unstable | (REC_W'(sync) ^ rec_q.resp);
            end
            if (samp_q == SAMP_W'(N_SAMP - 1)) begin
               state_d       = S_EMIT;
               rec_d.pattern = REC_W'(pat_q);
            end else begin
               samp_d = samp_q + 1'b1;
            end
         end
         S_EMIT: begin
            if (rec_ready) state_d = S_NEXT;
         end
         S_NEXT: begin
            if ((rec_q.unstable != '0) && (ucnt_q != '1)) ucnt_d = ucnt_q + 1'b1;
            if (pat_q == '1) begin
               state_d = S_DONE;
            end else begin
               pat_d   = pat_q + 1'b1;
               state_d = S_DRIVE;
            end
         end
         default: state_d = S_IDLE;
      endcase
      // Abort wins over everything while a sweep runs; a same-cycle transfer still happened.
      if (abort && busy) begin
         state_d = S_IDLE;
         pat_d   = '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         pat_q   <= '0;
         rec_q   <= '0;
         set_q   <= '0;
         samp_q  <= '0;
         ucnt_q  <= '0;
      end else begin
         state_q <= state_d;
         pat_q   <= pat_d;
         rec_q   <= rec_d;
         set_q   <= set_d;
         samp_q  <= samp_d;
         ucnt_q  <= ucnt_d;
      end
   end

   assign pat_out        = pat_q;
   assign rec_valid      = (state_q == S_EMIT);
   assign rec_pattern    = rec_q.pattern[N_IN-1:0];
   assign rec_resp       = rec_q.resp[N_OUT-1:0];
   assign rec_unstable   = rec_q.unstable[N_OUT-1:0];
   assign done           = (state_q == S_DONE);
   assign unstable_count = ucnt_q;
   assign unused_rec     = ^rec_q;

endmodule

// File: tb/tb_comb_sweep_monitor.sv
// Self-checking bench: a fake netlist (keyed loopback with an optional oscillating bit)
// and a pattern-level model of the expected record stream.
module tb_comb_sweep_monitor;

   localparam int N_IN   = 3;
   localparam int N_OUT  = 2;
   localparam int SETTLE = 2;
   localparam int N_SAMP = 3;
   localparam int PER    = 1 + SETTLE + N_SAMP + 1 + 1;
   localparam int NPAT   = 1 << N_IN;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic            start = 1'b0;
   logic            abort = 1'b0;
   logic [N_IN-1:0] pat_out;
   logic [N_OUT-1:0] resp_in;
   logic            rec_valid;
   logic            rec_ready = 1'b1;
   logic [N_IN-1:0] rec_pattern;
   logic [N_OUT-1:0] rec_resp;
   logic [N_OUT-1:0] rec_unstable;
   logic            busy;
   logic            done;
   logic [N_IN:0]   unstable_count;

   logic [1:0] key_r = 2'b00;
   logic [2:0] osc_pat_r = 3'd0;
   logic [1:0] osc_mask_r = 2'b00;
   logic       tog = 1'b0;

   int checks = 0;
   int failures = 0;

   comb_sweep_monitor #(.N_IN(N_IN), .N_OUT(N_OUT), .SETTLE(SETTLE), .N_SAMP(N_SAMP)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .start          (start),
      .abort          (abort),
      .pat_out        (pat_out),
      .resp_in        (resp_in),
      .rec_valid      (rec_valid),
      .rec_ready      (rec_ready),
      .rec_pattern    (rec_pattern),
      .rec_resp       (rec_resp),
      .rec_unstable   (rec_unstable),
      .busy           (busy),
      .done           (done),
      .unstable_count (unstable_count)
   );

   always #5 clk = ~clk;

   // Netlist stand-in: keyed loopback, one pattern optionally has bits toggling every clock.
   always @(posedge clk) tog <= ~tog;
   always_comb
      resp_in = (pat_out[1:0] ^ key_r) ^ ((pat_out == osc_pat_r) ? (osc_mask_r & {2{tog}}) : 2'b00);

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
      end
   endtask

   task automatic tick(output bit xfer);
      xfer = rec_valid && rec_ready;
      @(posedge clk);
      #1;
   endtask

   task automatic step();
      bit x;
      tick(x);
   endtask

   task automatic run_sweep(input logic [1:0] key, input logic [2:0] opat, input logic [1:0] omask,
                            input bit bp, input bit rnd);
      bit x, stalled, bp_stall;
      int nrec, since, stall, bp_n, budget, exp_uc;
      logic [2:0] p, rp;
      logic [1:0] m, er, rr, ru;
      logic [9:0] snap;
      key_r = key; osc_pat_r = opat; osc_mask_r = omask;
      exp_uc = (omask != 2'b00) ? 1 : 0;
      rec_ready = 1'b1;
      start = 1'b1; tick(x); start = 1'b0;
      chk("start_done", done, 0);
      chk("start_busy", busy, 1);
      chk("start_pat", pat_out, 0);
      chk("start_ucnt", unstable_count, 0);
      nrec = 0; since = 0; stall = 0; bp_n = 0; budget = 0; snap = '0;
      while (nrec < NPAT && budget < 2000) begin
         bp_stall = bp && rec_valid && (rec_pattern == 3'd2) && (bp_n < 10);
         if (bp_stall) rec_ready = 1'b0;
         else if (rnd) rec_ready = ($urandom_range(3, 0) != 0);
         else rec_ready = 1'b1;
         start = rnd && ($urandom_range(7, 0) == 0);
         stalled = rec_valid && !rec_ready;
         if (bp_stall && bp_n == 0) snap = {rec_pattern, rec_resp, rec_unstable, pat_out};
         rp = rec_pattern; rr = rec_resp; ru = rec_unstable;
         tick(x);
         since++; budget++;
         if (stalled) stall++;
         if (bp_stall) begin
            bp_n++;
            chk("bp_hold", {rec_valid, rec_pattern, rec_resp, rec_unstable, pat_out}, {1'b1, snap});
         end
         if (x) begin
            p  = 3'(nrec);
            m  = (p == opat) ? omask : 2'b00;
            er = p[1:0] ^ key;
            chk("rec_pat", rp, p);
            chk("rec_resp", rr & ~m, er & ~m);
            chk("rec_unst", ru, m);
            chk("rec_gap", since, ((nrec == 0) ? PER - 1 : PER) + stall);
            since = 0; stall = 0;
            nrec++;
         end
      end
      start = 1'b0;
      rec_ready = 1'b1;
      if (budget >= 2000) chk("sweep_timeout", nrec, NPAT);
      if (bp) chk("bp_cycles", bp_n, 10);
      tick(x);
      chk("end_done", done, 1);
      chk("end_busy", busy, 0);
      chk("end_valid", rec_valid, 0);
      chk("end_pat", pat_out, NPAT - 1);
      chk("end_ucnt", unstable_count, exp_uc);
   endtask

   initial begin
      int n;
      bit x;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_pat", pat_out, 0);
      chk("rst_valid", rec_valid, 0);
      chk("rst_recs", {rec_pattern, rec_resp, rec_unstable}, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_ucnt", unstable_count, 0);
      rst_n = 1'b1;
      step();

      run_sweep(2'b00, 3'd0, 2'b00, 1'b0, 1'b0);
      run_sweep(2'b00, 3'd5, 2'b01, 1'b0, 1'b0);
      run_sweep(2'(($urandom)), 3'd6, 2'b00, 1'b1, 1'b0);
      run_sweep(2'($urandom), 3'($urandom), 2'($urandom_range(3, 1)), 1'b0, 1'b1);

      // Abort in SETTLE of pattern 4; pattern 1 was unstable so the count should survive.
      key_r = 2'b00; osc_pat_r = 3'd1; osc_mask_r = 2'b10;
      rec_ready = 1'b1;
      start = 1'b1; step(); start = 1'b0;
      n = 0;
      while (pat_out != 3'd4 && n < 200) begin step(); n++; end
      if (n >= 200) chk("abort_wait", pat_out, 4);
      step();
      abort = 1'b1; step(); abort = 1'b0;
      chk("abort_busy", busy, 0);
      chk("abort_valid", rec_valid, 0);
      chk("abort_pat", pat_out, 0);
      chk("abort_done", done, 0);
      chk("abort_ucnt", unstable_count, 1);
      abort = 1'b1; step(); abort = 1'b0;
      chk("abort_idle", {busy, done, pat_out}, 0);
      run_sweep(2'b11, 3'd3, 2'b11, 1'b0, 1'b0);

      // Async reset while a record is held in EMIT.
      key_r = 2'b01; osc_mask_r = 2'b00;
      rec_ready = 1'b0;
      start = 1'b1; step(); start = 1'b0;
      n = 0;
      while (!rec_valid && n < 100) begin step(); n++; end
      chk("emit_reached", rec_valid, 1);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_valid", rec_valid, 0);
      chk("arst_busy", busy, 0);
      chk("arst_pat", pat_out, 0);
      chk("arst_recs", {rec_pattern, rec_resp, rec_unstable, done, unstable_count}, 0);
      step();
      rst_n = 1'b1;
      rec_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         step();
         chk("post_rst_idle", {busy, rec_valid, pat_out}, 0);
      end
      run_sweep(2'b10, 3'd7, 2'b01, 1'b1, 1'b1);

      tick(x);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL global_timeout got=%0t exp=<400000", $time);
      $fatal(1, "timeout");
   end

endmodule
